// File: rtl/wb_sram_bridge.sv
// Wishbone-classic slave bridging to two dual-port SRAM macros (A: 256 words, B: 512 words),
// plus a CSR block and a background checksum engine that scans a bank over port 1.
module wb_sram_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        csbA0,
  output logic        webA,
  output logic [3:0]  wmaskA,
  output logic [7:0]  addrA0,
  output logic [31:0] dinA0,
  output logic        csbA1,
  output logic [7:0]  addrA1,
  output logic        csbB0,
  output logic        webB,
  output logic [3:0]  wmaskB,
  output logic [8:0]  addrB0,
  output logic [31:0] dinB0,
  output logic        csbB1,
  output logic [8:0]  addrB1,
  input  logic [31:0] sram1_dout0,
  input  logic [31:0] sram1_dout1,
  input  logic [31:0] sram12_dout0,
  input  logic [31:0] sram12_dout1,
  output logic        busy_o
);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, ACC, RD, ACK} bus_state_e;
  typedef enum logic [1:0] {E_IDLE, E_RUN, E_DRAIN} eng_state_e;

  // wadr holds byte address bits [12:2]
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [10:0] wadr;
    logic [31:0] dat;
  } wb_req_t;

  bus_state_e  state_q, state_d;
  wb_req_t     req_q, req_d;
  logic [31:0] dat_q, dat_d;
  logic        hit, csr_wr;
  logic [1:0]  region, csr_idx;
  logic [31:0] csr_rdata;
  logic        unused_adr;

  eng_state_e  e_state_q, e_state_d;
  logic [9:0]  len_q, len_eff_q, len_start, idx_q;
  logic        bank_q, scan_bank_q, done_q;
  logic [31:0] sum_q, rdata_q, dout1_sel;
  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;
  logic        issue, start, busy;

  assign unused_adr = ^wbs_adr_i[1:0];
  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:13] == BASE_ADDR[31:13]);
  assign region     = req_q.wadr[10:9];
  assign csr_idx    = req_q.wadr[1:0];

  // ---------------- bus FSM ----------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    dat_d   = dat_q;
    csr_wr  = 1'b0;
    case (state_q)
      IDLE: if (hit) begin
        req_d   = '{we: wbs_we_i, sel: wbs_sel_i, wadr: wbs_adr_i[12:2], dat: wbs_dat_i};
        state_d = ACC;
      end
      ACC: begin
        state_d = ACK;
        case (region)
          2'b00, 2'b01: if (!req_q.we) state_d = RD;
          2'b10: if (req_q.we) csr_wr = 1'b1;
                 else          dat_d  = csr_rdata;
          default: if (!req_q.we) dat_d = '0;
        endcase
      end
      RD: begin
        dat_d   = (region == 2'b01) ? sram12_dout0 : sram1_dout0;
        state_d = ACK;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = (state_q == ACK) & wbs_cyc_i & wbs_stb_i;

  // Port 0 is only active for the single ACC cycle; parked at idle values otherwise.
  always_comb begin
    csbA0  = 1'b1;
    webA   = 1'b1;
    wmaskA = '0;
    addrA0 = '0;
    dinA0  = '0;
    csbB0  = 1'b1;
    webB   = 1'b1;
    wmaskB = '0;
    addrB0 = '0;
    dinB0  = '0;
    if (state_q == ACC) begin
      if (region == 2'b00) begin
        csbA0  = 1'b0;
        webA   = ~req_q.we;
        wmaskA = req_q.we ? req_q.sel : 4'b0;
        addrA0 = req_q.wadr[7:0];
        dinA0  = req_q.dat;
      end else if (region == 2'b01) begin
        csbB0  = 1'b0;
        webB   = ~req_q.we;
        wmaskB = req_q.we ? req_q.sel : 4'b0;
        addrB0 = req_q.wadr[8:0];
        dinB0  = req_q.dat;
      end
    end
  end

  // ---------------- CSR / checksum engine ----------------
  assign busy  = (e_state_q != E_IDLE);
  assign start = csr_wr & (csr_idx == 2'd0) & req_q.dat[0] & ~busy;

  always_comb begin
    if (req_q.dat[1]) len_start = (len_q > 10'd512) ? 10'd512 : len_q;
    else              len_start = (len_q > 10'd256) ? 10'd256 : len_q;
  end

  always_comb begin
    case (csr_idx)
      2'd0:    csr_rdata = {29'b0, done_q, bank_q, busy};
      2'd1:    csr_rdata = {22'b0, len_q};
      2'd2:    csr_rdata = sum_q;
      default: csr_rdata = '0;
    endcase
  end

  always_comb begin
    e_state_d = e_state_q;
    issue     = 1'b0;
    case (e_state_q)
      E_IDLE:  if (start && len_start != 10'd0) e_state_d = E_RUN;
      E_RUN: begin
        issue = 1'b1;
        if (idx_q == len_eff_q - 10'd1) e_state_d = E_DRAIN;
      end
      E_DRAIN: if (vld_pipe[STAGES:1] == '0) e_state_d = E_IDLE;
      default: e_state_d = E_IDLE;
    endcase
  end

  // Stage 1 registers the SRAM read data, stage 2 accumulates it.
  assign vld_pipe  = {vld_q, issue};
  assign dout1_sel = scan_bank_q ? sram12_dout1 : sram1_dout1;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      e_state_q   <= E_IDLE;
      len_q       <= '0;
      len_eff_q   <= '0;
      idx_q       <= '0;
      bank_q      <= 1'b0;
      scan_bank_q <= 1'b0;
      done_q      <= 1'b0;
      sum_q       <= '0;
      rdata_q     <= '0;
      vld_q       <= '0;
    end else begin
      e_state_q <= e_state_d;
      vld_q     <= vld_pipe[STAGES-1:0];
      if (vld_pipe[1]) rdata_q <= dout1_sel;
      if (vld_pipe[2]) sum_q   <= sum_q + rdata_q;
      if (e_state_q == E_RUN) idx_q <= idx_q + 10'd1;
      if (e_state_q == E_DRAIN && e_state_d == E_IDLE) done_q <= 1'b1;
      if (csr_wr && csr_idx == 2'd1) len_q  <= req_q.dat[9:0];
      if (csr_wr && csr_idx == 2'd0) bank_q <= req_q.dat[1];
      if (start) begin
        sum_q       <= '0;
        idx_q       <= '0;
        len_eff_q   <= len_start;
        scan_bank_q <= req_q.dat[1];
        done_q      <= (len_start == 10'd0);
      end
    end
  end

  assign busy_o = busy;
  assign csbA1  = ~(issue & ~scan_bank_q);
  assign addrA1 = (issue & ~scan_bank_q) ? idx_q[7:0] : 8'd0;
  assign csbB1  = ~(issue & scan_bank_q);
  assign addrB1 = (issue & scan_bank_q) ? idx_q[8:0] : 9'd0;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Bench for wb_sram_bridge: behavioral dual-port SRAMs, an expected-memory model and a read scoreboard.
module tb_wb_sram_bridge;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat_w = '0;
  logic        wbs_ack_o, csbA0, webA, csbA1, csbB0, webB, csbB1, busy_o;
  logic [31:0] wbs_dat_o, dinA0, dinB0;
  logic [3:0]  wmaskA, wmaskB;
  logic [7:0]  addrA0, addrA1;
  logic [8:0]  addrB0, addrB1;
  logic [31:0] doA0, doA1, doB0, doB1;

  logic [31:0] memA [256];
  logic [31:0] memB [512];
  logic [31:0] expA [256];
  logic [31:0] expB [512];
  logic [31:0] exp_q [$];
  int          logA [$];
  int          logB [$];
  int          checks = 0, errors = 0;
  logic        s_csbA0, s_webA, s_csbB0, s_webB;
  logic [3:0]  s_wmaskA, s_wmaskB;
  logic [7:0]  s_addrA0;
  logic [8:0]  s_addrB0;
  logic [31:0] s_dinA0;

  always #5 clk = ~clk;

  wb_sram_bridge dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .csbA0(csbA0), .webA(webA), .wmaskA(wmaskA), .addrA0(addrA0), .dinA0(dinA0),
    .csbA1(csbA1), .addrA1(addrA1),
    .csbB0(csbB0), .webB(webB), .wmaskB(wmaskB), .addrB0(addrB0), .dinB0(dinB0),
    .csbB1(csbB1), .addrB1(addrB1),
    .sram1_dout0(doA0), .sram1_dout1(doA1), .sram12_dout0(doB0), .sram12_dout1(doB1),
    .busy_o(busy_o)
  );

  // SRAM macros: synchronous read/write, one-cycle read latency
  always @(posedge clk) begin
    if (!csbA0) begin
      if (!webA) begin
        for (int b = 0; b < 4; b++) if (wmaskA[b]) memA[addrA0][8*b +: 8] <= dinA0[8*b +: 8];
      end else doA0 <= memA[addrA0];
    end
    if (!csbA1) doA1 <= memA[addrA1];
    if (!csbB0) begin
      if (!webB) begin
        for (int b = 0; b < 4; b++) if (wmaskB[b]) memB[addrB0][8*b +: 8] <= dinB0[8*b +: 8];
      end else doB0 <= memB[addrB0];
    end
    if (!csbB1) doB1 <= memB[addrB1];
    if (!csbA1) logA.push_back(int'(addrA1));
    if (!csbB1) logB.push_back(int'(addrB1));
  end

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rdat, output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    lat = 0; rdat = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        s_csbA0 = csbA0; s_webA = webA; s_wmaskA = wmaskA; s_addrA0 = addrA0; s_dinA0 = dinA0;
        s_csbB0 = csbB0; s_webB = webB; s_wmaskB = wmaskB; s_addrB0 = addrB0;
      end
      if (wbs_ack_o) begin lat = c; rdat = wbs_dat_o; break; end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int lat);
    logic [31:0] unused_r;
    bus(1'b1, a, d, s, unused_r, lat);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r, output int lat);
    bus(1'b0, a, 32'h0, 4'hF, r, lat);
  endtask

  task automatic wait_idle(output int ok);
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!busy_o) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    #3;
    checks++; if ({csbA0, csbA1, csbB0, csbB1, webA, webB} !== 6'h3F) begin errors++;
      $display("FAIL reset_csb_web got=%b exp=111111", {csbA0, csbA1, csbB0, csbB1, webA, webB}); end
    checks++; if ({wbs_ack_o, busy_o} !== 2'b00) begin errors++;
      $display("FAIL reset_ack_busy got=%b exp=00", {wbs_ack_o, busy_o}); end
    checks++; if (wbs_dat_o !== 32'h0) begin errors++;
      $display("FAIL reset_dat got=%h exp=0", wbs_dat_o); end
    checks++; if ({addrA0, addrA1, addrB0, addrB1, dinA0, dinB0, wmaskA, wmaskB} !== '0) begin errors++;
      $display("FAIL reset_addr_din_mask not all zero"); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic init_mem;
    int lat, bad;
    logic [31:0] v;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom; wr(BASE + 32'(i * 4), v, 4'hF, lat); expA[i] = v; if (lat != 2) bad++;
    end
    for (int i = 0; i < 512; i++) begin
      v = $urandom; wr(BASE + 32'h800 + 32'(i * 4), v, 4'hF, lat); expB[i] = v; if (lat != 2) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL init_write_ack bad=%0d exp=0", bad); end
  endtask

  task automatic test_write_a;
    int lat; logic [31:0] r, e, held;
    wr(BASE + 32'h010, 32'hA5A5_1234, 4'b0011, lat);
    expA[4] = {expA[4][31:16], 16'h1234};
    checks++; if ({s_csbA0, s_webA} !== 2'b00 || s_wmaskA !== 4'b0011) begin errors++;
      $display("FAIL wr_a_t1_ctl got csb/web=%b mask=%b exp 00/0011", {s_csbA0, s_webA}, s_wmaskA); end
    checks++; if (s_addrA0 !== 8'd4 || s_dinA0 !== 32'hA5A5_1234) begin errors++;
      $display("FAIL wr_a_t1_addr got addr=%0d din=%h exp 4/a5a51234", s_addrA0, s_dinA0); end
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_a_lat got=%0d exp=2", lat); end
    @(posedge clk); #1;
    checks++; if ({csbA0, webA, wmaskA, addrA0, dinA0} !== {2'b11, 44'h0}) begin errors++;
      $display("FAIL port0_idle csb=%b web=%b mask=%b addr=%h din=%h", csbA0, webA, wmaskA, addrA0, dinA0); end
    exp_q.push_back(expA[4]);
    rd(BASE + 32'h010, r, lat);
    e = exp_q.pop_front();
    checks++; if (r !== e || lat != 3) begin errors++;
      $display("FAIL rd_a_back got=%h lat=%0d exp=%h lat=3", r, lat, e); end
    exp_q.push_back(expA[4]);
    rd(BASE + 32'h410, r, lat);
    e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL rd_a_alias got=%h exp=%h", r, e); end
    held = e;
    wr(BASE + 32'h014, expA[5], 4'hF, lat);
    checks++; if (wbs_dat_o !== held) begin errors++;
      $display("FAIL dat_hold got=%h exp=%h", wbs_dat_o, held); end
  endtask

  task automatic test_read_b;
    int lat; logic [31:0] r, e;
    wr(BASE + 32'h804, 32'hCAFE_F00D, 4'hF, lat); expB[1] = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_F00D);
    rd(BASE + 32'h804, r, lat);
    e = exp_q.pop_front();
    checks++; if ({s_csbB0, s_webB, s_wmaskB, s_addrB0, s_csbA0} !== {2'b01, 4'b0, 9'd1, 1'b1}) begin errors++;
      $display("FAIL rd_b_t1 csb=%b web=%b mask=%b addr=%0d csbA=%b exp 0/1/0/1/1",
               s_csbB0, s_webB, s_wmaskB, s_addrB0, s_csbA0); end
    checks++; if (r !== e || lat != 3) begin errors++;
      $display("FAIL rd_b_data got=%h lat=%0d exp=%h lat=3", r, lat, e); end
  endtask

  task automatic test_miss_reserved;
    int lat, bad; logic [31:0] r, e;
    bad = 0;
    @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h2000_0000; dat_w = 32'hDEAD_BEEF; sel = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (wbs_ack_o || !csbA0 || !csbB0 || !csbA1 || !csbB1) bad++;
      if (c == 3) we = 1'b0;
    end
    @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL miss_quiet bad_cycles=%0d exp=0", bad); end
    exp_q.push_back(32'h0);
    rd(BASE + 32'h1800, r, lat);
    e = exp_q.pop_front();
    checks++; if (r !== e || lat != 2) begin errors++;
      $display("FAIL reserved_rd got=%h lat=%0d exp=%h lat=2", r, lat, e); end
    wr(BASE + 32'h1800, 32'h1234_5678, 4'hF, lat);
    checks++; if (lat != 2 || s_csbA0 !== 1'b1 || s_csbB0 !== 1'b1) begin errors++;
      $display("FAIL reserved_wr lat=%0d csbA0=%b csbB0=%b exp 2/1/1", lat, s_csbA0, s_csbB0); end
  endtask

  task automatic test_csr;
    int lat; logic [31:0] r, e;
    exp_q.push_back(32'h0);
    rd(BASE + 32'h1000, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL ctrl_initial got=%h exp=%h", r, e); end
    wr(BASE + 32'h1004, 32'hFFFF_FFFF, 4'hF, lat);
    exp_q.push_back(32'h3FF);
    rd(BASE + 32'h1004, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e || lat != 2) begin errors++;
      $display("FAIL len_rw got=%h lat=%0d exp=%h lat=2", r, lat, e); end
    exp_q.push_back(32'h0);
    rd(BASE + 32'h100C, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL csr_idx3 got=%h exp=%h", r, e); end
  endtask

  task automatic test_scan_b;
    int lat, ok; logic [31:0] r, e;
    for (int i = 0; i < 3; i++) begin
      wr(BASE + 32'h800 + 32'(i * 4), 32'(i + 1), 4'hF, lat); expB[i] = 32'(i + 1);
    end
    wr(BASE + 32'h1004, 32'd3, 4'hF, lat);
    logA.delete(); logB.delete();
    wr(BASE + 32'h1000, 32'b11, 4'hF, lat);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL scan_b_timeout busy=%b exp=0", busy_o); end
    checks++; if (logB.size() != 3 || logB[0] != 0 || logB[1] != 1 || logB[2] != 2 || logA.size() != 0) begin
      errors++; $display("FAIL scan_b_addrs got nB=%0d nA=%0d exp addrs 0,1,2 on B only", logB.size(), logA.size()); end
    exp_q.push_back(32'd6);
    rd(BASE + 32'h1008, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL scan_b_sum got=%h exp=%h", r, e); end
    exp_q.push_back(32'b110);
    rd(BASE + 32'h1000, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL scan_b_ctrl got=%h exp=%h", r, e); end
  endtask

  task automatic test_scan_a_clip;
    int lat, ok, bad; logic [31:0] r, e, s;
    s = '0; bad = 0;
    for (int i = 0; i < 256; i++) s += expA[i];
    wr(BASE + 32'h1004, 32'd1000, 4'hF, lat);
    logA.delete(); logB.delete();
    wr(BASE + 32'h1000, 32'b01, 4'hF, lat);
    wait_idle(ok);
    for (int i = 0; i < logA.size(); i++) if (logA[i] != i) bad++;
    checks++; if (!ok || logA.size() != 256 || bad != 0 || logB.size() != 0) begin errors++;
      $display("FAIL scan_a_clip ok=%0d nA=%0d bad=%0d nB=%0d exp 1/256/0/0", ok, logA.size(), bad, logB.size()); end
    checks++; if (logA.size() == 256 && logA[255] != 255) begin errors++;
      $display("FAIL scan_a_last got=%0d exp=255", logA[255]); end
    exp_q.push_back(s);
    rd(BASE + 32'h1008, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL scan_a_sum got=%h exp=%h", r, e); end
    exp_q.push_back(32'b100);
    rd(BASE + 32'h1000, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL scan_a_ctrl got=%h exp=%h", r, e); end
  endtask

  task automatic test_len0;
    int lat; logic [31:0] r, e;
    wr(BASE + 32'h1004, 32'd0, 4'hF, lat);
    logB.delete();
    wr(BASE + 32'h1000, 32'b11, 4'hF, lat);
    @(posedge clk); #1;
    checks++; if (busy_o !== 1'b0 || logB.size() != 0) begin errors++;
      $display("FAIL len0_busy busy=%b nB=%0d exp 0/0", busy_o, logB.size()); end
    exp_q.push_back(32'b110);
    rd(BASE + 32'h1000, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL len0_ctrl got=%h exp=%h", r, e); end
    exp_q.push_back(32'h0);
    rd(BASE + 32'h1008, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL len0_sum got=%h exp=%h", r, e); end
  endtask

  task automatic test_overlap;
    int lat, ok; logic [31:0] r, e, s;
    s = '0;
    for (int i = 0; i < 512; i++) s += expB[i];
    wr(BASE + 32'h1004, 32'd1023, 4'hF, lat);
    logA.delete(); logB.delete();
    wr(BASE + 32'h1000, 32'b11, 4'hF, lat);
    wr(BASE + 32'h1000, 32'b01, 4'hF, lat);
    exp_q.push_back(expA[7]);
    rd(BASE + 32'h01C, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e || busy_o !== 1'b1) begin errors++;
      $display("FAIL port0_during_scan got=%h busy=%b exp=%h busy=1", r, busy_o, e); end
    wait_idle(ok);
    checks++; if (!ok || logB.size() != 512 || logA.size() != 0) begin errors++;
      $display("FAIL start_while_busy ok=%0d nB=%0d nA=%0d exp 1/512/0", ok, logB.size(), logA.size()); end
    exp_q.push_back(s);
    rd(BASE + 32'h1008, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL scan_b_full_sum got=%h exp=%h", r, e); end
  endtask

  task automatic test_drop;
    int lat, bad; logic [31:0] r, e;
    bad = 0;
    @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h020; dat_w = 32'h1111_2222; sel = 4'hF;
    @(posedge clk); #1;
    if (csbA0 !== 1'b0) bad++;
    @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0;
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; if (wbs_ack_o) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL drop_no_ack bad=%0d exp=0", bad); end
    expA[8] = 32'h1111_2222;
    exp_q.push_back(expA[8]);
    rd(BASE + 32'h020, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL drop_write_done got=%h exp=%h", r, e); end
  endtask

  task automatic test_reset_mid;
    int lat, bad; logic [31:0] r, e;
    bad = 0;
    wr(BASE + 32'h1004, 32'd500, 4'hF, lat);
    wr(BASE + 32'h1000, 32'b11, 4'hF, lat);
    repeat (5) @(posedge clk);
    @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h804; sel = 4'hF;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    checks++; if ({csbA0, csbA1, csbB0, csbB1, webA, webB} !== 6'h3F || {wbs_ack_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_ctl csb/web=%b ack/busy=%b exp 111111/00",
                         {csbA0, csbA1, csbB0, csbB1, webA, webB}, {wbs_ack_o, busy_o}); end
    checks++; if (wbs_dat_o !== 32'h0 || {addrA0, addrA1, addrB0, addrB1, dinA0, dinB0, wmaskA, wmaskB} !== '0) begin
      errors++; $display("FAIL mid_reset_data dat=%h exp=0 and zero addr/din/mask", wbs_dat_o); end
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (wbs_ack_o) bad++; end
    @(negedge clk); cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (wbs_ack_o) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_reset_no_ack bad=%0d exp=0", bad); end
    exp_q.push_back(32'h0);
    rd(BASE + 32'h1000, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL post_reset_ctrl got=%h exp=%h", r, e); end
    exp_q.push_back(32'h0);
    rd(BASE + 32'h1004, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL post_reset_len got=%h exp=%h", r, e); end
    exp_q.push_back(32'h0);
    rd(BASE + 32'h1008, r, lat); e = exp_q.pop_front();
    checks++; if (r !== e) begin errors++; $display("FAIL post_reset_sum got=%h exp=%h", r, e); end
  endtask

  initial begin
    test_reset;
    init_mem;
    test_write_a;
    test_read_b;
    test_miss_reserved;
    test_csr;
    test_scan_b;
    test_scan_a_clip;
    test_len0;
    test_overlap;
    test_drop;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout sim did not complete");
    $fatal(1, "timeout");
  end
endmodule
